// File: rtl/tia_player_object.sv
// Player-graphics object stage.
// Runs a LINE_PIXELS-position horizontal counter that advances on the motion clock or on
// HMOVE pulses. It decodes NUSIZ copy boundaries into registered start strobes and
// serialises the player graphic at 1x/2x/4x width into a one-bit pixel.
//
// Ports:
//   clk        master colour clock
//   reset      synchronous active-high reset; overrides every other input
//   motck      count enable, one cycle per visible pixel
//   hmove_clk  extra count-enable pulse from the HMOVE logic
//   resp       reposition strobe; the counter goes to 0 and the serialiser goes idle
//   nusiz      number/size select
//   refp       reflect; 1 = serialise grp LSB first
//   grp        player graphic, sampled live
//   count      horizontal position 0..LINE_PIXELS-1
//   start      one-cycle pulse aligned with the count value where a copy begins
//   copy       copy index of the current/last start
//   pix        serialised player pixel
module tia_player_object #(
    parameter int unsigned LINE_PIXELS = 160,
    parameter int unsigned GFX_BITS    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                motck,
    input  logic                hmove_clk,
    input  logic                resp,
    input  logic [2:0]          nusiz,
    input  logic                refp,
    input  logic [GFX_BITS-1:0] grp,
    output logic [7:0]          count,
    output logic                start,
    output logic [1:0]          copy,
    output logic                pix
);

    localparam int unsigned IdxW = $clog2(GFX_BITS);
    localparam logic [IdxW-1:0] MaxIdx = IdxW'(GFX_BITS - 1);
    localparam logic [7:0] LastPos = 8'(LINE_PIXELS - 1);

    logic [7:0]      count_q, count_d, count_inc;
    logic            start_q, start_d;
    logic [1:0]      copy_q, copy_d;
    logic            active_q, active_d;
    logic [IdxW-1:0] bit_q, bit_d;
    logic [1:0]      sub_q, sub_d;

    logic            tick;
    logic            hit;
    logic [1:0]      hit_copy;
    logic [1:0]      sub_max;

    // Both enables together still produce only one advance.
    assign tick      = motck | hmove_clk;
    assign count_inc = (count_q == LastPos) ? 8'd0 : count_q + 8'd1;

    // Boundary decode on the value the counter is about to take.
    always_comb begin
        hit      = 1'b0;
        hit_copy = 2'd0;
        if (count_inc == 8'd0) begin
            hit = 1'b1;
        end else begin
            case (nusiz)
                3'b001: if (count_inc == 8'd16) begin hit = 1'b1; hit_copy = 2'd1; end
                3'b010: if (count_inc == 8'd32) begin hit = 1'b1; hit_copy = 2'd1; end
                3'b011: begin
                    if (count_inc == 8'd16) begin hit = 1'b1; hit_copy = 2'd1; end
                    if (count_inc == 8'd32) begin hit = 1'b1; hit_copy = 2'd2; end
                end
                3'b100: if (count_inc == 8'd64) begin hit = 1'b1; hit_copy = 2'd1; end
                3'b110: begin
                    if (count_inc == 8'd32) begin hit = 1'b1; hit_copy = 2'd1; end
                    if (count_inc == 8'd64) begin hit = 1'b1; hit_copy = 2'd2; end
                end
                default: ;
            endcase
        end
    end

    // Pixel stretch factor minus one: 4x for 111, 2x for 101, 1x otherwise.
    always_comb begin
        case (nusiz)
            3'b111:  sub_max = 2'd3;
            3'b101:  sub_max = 2'd1;
            default: sub_max = 2'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 8'd0;
            start_q  <= 1'b0;
            copy_q   <= 2'd0;
            active_q <= 1'b0;
            bit_q    <= '0;
            sub_q    <= 2'd0;
        end else begin
            count_q  <= count_d;
            start_q  <= start_d;
            copy_q   <= copy_d;
            active_q <= active_d;
            bit_q    <= bit_d;
            sub_q    <= sub_d;
        end
    end

    // Next-state logic
    always_comb begin
        count_d  = count_q;
        start_d  = 1'b0;
        copy_d   = copy_q;
        active_d = active_q;
        bit_d    = bit_q;
        sub_d    = sub_q;
        if (resp) begin
            count_d  = 8'd0;
            active_d = 1'b0;
            bit_d    = '0;
            sub_d    = 2'd0;
        end else if (tick) begin
            count_d = count_inc;
            if (hit) begin
                // A new copy restarts the serialiser even mid-graphic.
                start_d  = 1'b1;
                copy_d   = hit_copy;
                active_d = 1'b1;
                bit_d    = '0;
                sub_d    = 2'd0;
            end else if (active_q) begin
                // >= so that shrinking the width mid-copy wraps on the next tick.
                if (sub_q >= sub_max) begin
                    sub_d = 2'd0;
                    if (bit_q == MaxIdx) begin
                        active_d = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    sub_d = sub_q + 2'd1;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        count = count_q;
        start = start_q;
        copy  = copy_q;
        pix   = active_q & (refp ? grp[bit_q] : grp[MaxIdx - bit_q]);
    end

endmodule

// File: tb/tb_tia_player_object.sv
module tb_tia_player_object;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       motck = 1'b0;
    logic       hmove_clk = 1'b0;
    logic       resp = 1'b0;
    logic [2:0] nusiz = 3'd0;
    logic       refp = 1'b0;
    logic [7:0] grp = 8'd0;
    logic [7:0] count;
    logic       start;
    logic [1:0] copy;
    logic       pix;

    int n_vec = 0;
    int n_err = 0;

    tia_player_object dut (
        .clk       (clk),
        .reset     (reset),
        .motck     (motck),
        .hmove_clk (hmove_clk),
        .resp      (resp),
        .nusiz     (nusiz),
        .refp      (refp),
        .grp       (grp),
        .count     (count),
        .start     (start),
        .copy      (copy),
        .pix       (pix)
    );

    always #5 clk = ~clk;

    // Reference model: position on the line, plus "ticks since the last copy began".
    int m_count  = 0;
    bit m_start  = 0;
    int m_copy   = 0;
    bit m_active = 0;
    int m_off    = 0;
    int m_scale  = 1;

    // A copy list is described as (number of copies, spacing in pixels).
    function automatic int copy_at(logic [2:0] ns, int n);
        int copies;
        int gap;
        if (n == 0) return 0;
        case (ns)
            3'd1:    begin copies = 2; gap = 16; end
            3'd2:    begin copies = 2; gap = 32; end
            3'd3:    begin copies = 3; gap = 16; end
            3'd4:    begin copies = 2; gap = 64; end
            3'd6:    begin copies = 3; gap = 32; end
            default: begin copies = 1; gap = 0;  end
        endcase
        if (gap != 0 && n % gap == 0 && n / gap < copies) return n / gap;
        return -1;
    endfunction

    function automatic int scale_of(logic [2:0] ns);
        return (ns == 3'd7) ? 4 : (ns == 3'd5) ? 2 : 1;
    endfunction

    function automatic bit model_pix();
        int b;
        if (!m_active) return 1'b0;
        b = m_off / m_scale;
        return refp ? grp[b] : grp[7 - b];
    endfunction

    always @(posedge clk) begin
        int c;
        if (reset) begin
            m_count = 0; m_start = 0; m_copy = 0; m_active = 0; m_off = 0;
        end else if (resp) begin
            m_count = 0; m_start = 0; m_active = 0;
        end else if (motck || hmove_clk) begin
            m_count = (m_count + 1) % 160;
            c = copy_at(nusiz, m_count);
            if (c >= 0) begin
                m_start = 1; m_copy = c; m_active = 1; m_off = 0; m_scale = scale_of(nusiz);
            end else begin
                m_start = 0;
                if (m_active) begin
                    m_off++;
                    if (m_off >= 8 * m_scale) m_active = 0;
                end
            end
        end else begin
            m_start = 0;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        bit bad;
        bad = 0;
        if (int'(count) != m_count) begin
            $display("FAIL cyc_count t=%0t got=%0d want=%0d", $time, count, m_count); bad = 1;
        end
        if (start !== m_start) begin
            $display("FAIL cyc_start t=%0t got=%b want=%b", $time, start, m_start); bad = 1;
        end
        if (int'(copy) != m_copy) begin
            $display("FAIL cyc_copy t=%0t got=%0d want=%0d", $time, copy, m_copy); bad = 1;
        end
        if (pix !== model_pix()) begin
            $display("FAIL cyc_pix t=%0t got=%b want=%b", $time, pix, model_pix()); bad = 1;
        end
        n_vec++;
        if (bad) n_err++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle, then return just after the edge that consumed the inputs.
    task automatic apply(input bit m, input bit h, input bit rp, input bit rs);
        @(negedge clk);
        #1;
        motck = m; hmove_clk = h; resp = rp; reset = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int q_cnt[$];
        int q_cpy[$];
        int ones;
        int sum;
        int ticks;
        bit seen;
        logic [7:0] pat;
        pat = 8'b1010_0101;

        // 1. Reset dominates a running motion clock.
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, 1);
            chk("reset_count", count, 0);
            chk("reset_start", start, 0);
            chk("reset_pix", pix, 0);
        end

        // 2. One full line, single copy, MSB first.
        nusiz = 3'b000; grp = 8'hA5; refp = 0;
        apply(0, 0, 1, 0);
        seen = 0;
        for (int i = 0; i < 159; i++) begin
            apply(1, 0, 0, 0);
            if (start) seen = 1;
        end
        chk("line_no_early_start", seen, 0);
        apply(1, 0, 0, 0);
        chk("wrap_start", start, 1);
        chk("wrap_copy", copy, 0);
        chk("wrap_count", count, 0);
        chk("pix_at_0", pix, pat[7]);
        for (int i = 1; i < 9; i++) begin
            apply(1, 0, 0, 0);
            chk("pix_pattern", pix, (i < 8) ? int'(pat[7 - i]) : 0);
        end

        // 3. Three close copies.
        nusiz = 3'b011;
        apply(0, 0, 1, 0);
        for (int i = 0; i < 160; i++) begin
            apply(1, 0, 0, 0);
            if (start) begin q_cnt.push_back(count); q_cpy.push_back(copy); end
        end
        chk("close3_nstarts", q_cnt.size(), 3);
        if (q_cnt.size() == 3) begin
            chk("close3_pos0", q_cnt[0], 16); chk("close3_cpy0", q_cpy[0], 1);
            chk("close3_pos1", q_cnt[1], 32); chk("close3_cpy1", q_cpy[1], 2);
            chk("close3_pos2", q_cnt[2], 0);  chk("close3_cpy2", q_cpy[2], 0);
        end

        // 4. Quad and double width, reflected, single set bit.
        refp = 1; grp = 8'h01;
        for (int k = 0; k < 2; k++) begin
            apply(0, 0, 1, 0);
            nusiz = (k == 0) ? 3'b111 : 3'b101;
            ones = 0; sum = 0;
            for (int i = 0; i < 200; i++) begin
                apply(1, 0, 0, 0);
                if (pix) begin ones++; sum += count; end
            end
            chk(k == 0 ? "quad_ones" : "double_ones", ones, k == 0 ? 4 : 2);
            chk(k == 0 ? "quad_sum" : "double_sum", sum, k == 0 ? 6 : 1);
        end

        // 5. Coincident enables and HMOVE pulses.
        nusiz = 3'b000; refp = 0; grp = 8'hFF;
        apply(0, 0, 1, 0);
        apply(1, 1, 0, 0);
        chk("both_enables", count, 1);
        apply(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) apply(0, 1, 0, 0);
        chk("hmove_count", count, 8);
        ticks = 200;
        for (int i = 1; i <= 200; i++) begin
            apply(1, 0, 0, 0);
            if (start) begin ticks = i; break; end
        end
        chk("hmove_early_start", ticks, 152);

        // 6. Reset mid-graphic, and reset together with resp.
        apply(0, 0, 1, 0);
        for (int i = 0; i < 163; i++) apply(1, 0, 0, 0);
        chk("mid_count", count, 3);
        chk("mid_pix", pix, 1);
        apply(1, 0, 0, 1);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_pix", pix, 0);
        chk("rst_mid_start", start, 0);
        nusiz = 3'b011;
        apply(0, 0, 1, 0);
        for (int i = 0; i < 19; i++) apply(1, 0, 0, 0);
        chk("pre_copy", copy, 1);
        apply(1, 0, 1, 1);
        chk("rstresp_count", count, 0);
        chk("rstresp_copy", copy, 0);
        chk("rstresp_pix", pix, 0);
        chk("rstresp_start", start, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            motck     = ($urandom_range(0, 9) != 0);
            hmove_clk = ($urandom_range(0, 5) == 0);
            resp      = ($urandom_range(0, 199) == 0);
            reset     = ($urandom_range(0, 599) == 0);
            grp       = 8'($urandom);
            refp      = 1'($urandom);
            if (!m_active && $urandom_range(0, 19) == 0) nusiz = 3'($urandom);
            @(posedge clk);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
